// File: rtl/disp_num_ctrl.sv
// Number-to-7-segment display controller: latches a value on dval and renders it as hex,
// unsigned decimal or signed decimal on NDIG active-low digits via a double-dabble converter.
module disp_num_ctrl #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 4,
  parameter int LZB   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   din,
  input  logic               dval,
  input  logic [1:0]         mode,
  input  logic               enable,
  output logic [7*NDIG-1:0]  disp,
  output logic               busy,
  output logic               ovf
);

  localparam int BCDW = 4 * NDIG;
  localparam int HEXW = 4 * NDIG;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NNIB = (WIDTH + 3) / 4;

  localparam logic [6:0]        SEG_BLANK = 7'h7F;
  localparam logic [6:0]        SEG_MINUS = 7'h3F;
  localparam logic [6:0]        SEG_E     = 7'h06;
  localparam logic [7*NDIG-1:0] ALL_BLANK = {NDIG{SEG_BLANK}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_OUTPUT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]  data_q;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  pend_data;
  logic [1:0]        pend_mode;
  logic              pend_valid;
  logic [WIDTH-1:0]  mag;
  logic [BCDW-1:0]   bcd;
  logic [BCDW-1:0]   bcd_adj;
  logic              neg;
  logic              bcd_ovf;
  logic [CW-1:0]     cnt;
  logic [7*NDIG-1:0] disp_q;
  logic [7*NDIG-1:0] disp_next;
  logic              ovf_q;
  logic              ovf_next;
  logic              en_q;
  logic              is_dec;
  logic              is_signed;

  // Mode 2'b11 deliberately falls into the hex path.
  assign is_dec    = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign is_signed = (mode_q == 2'b10);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (dval) state_next = S_LOAD;
      S_LOAD:   state_next = is_dec ? S_CONV : S_OUTPUT;
      S_CONV:   if (cnt == CW'(WIDTH - 1)) state_next = S_OUTPUT;
      S_OUTPUT: state_next = (dval || pend_valid) ? S_LOAD : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Render the converted value; minus sits just left of the most significant nonzero digit.
  always_comb begin
    logic [HEXW-1:0] hex_pad;
    int              msd;
    logic            dec_err;
    disp_next = ALL_BLANK;
    ovf_next  = 1'b0;
    hex_pad   = HEXW'(data_q);
    msd       = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    dec_err = bcd_ovf || (neg && (msd == NDIG - 1));
    if (!is_dec) begin
      ovf_next = (NNIB > NDIG);
      for (int i = 0; i < NDIG; i++) begin
        if (i < NNIB) disp_next[7*i +: 7] = seg7(hex_pad[4*i +: 4]);
      end
    end else if (dec_err) begin
      disp_next[6:0] = SEG_E;
      ovf_next       = 1'b1;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (neg && (i == msd + 1))       disp_next[7*i +: 7] = SEG_MINUS;
        else if ((i <= msd) || (LZB == 0)) disp_next[7*i +: 7] = seg7(bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q     <= '0;
      mode_q     <= '0;
      pend_data  <= '0;
      pend_mode  <= '0;
      pend_valid <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      neg        <= 1'b0;
      bcd_ovf    <= 1'b0;
      cnt        <= '0;
      disp_q     <= ALL_BLANK;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      en_q <= enable;

      // Strobes arriving mid-conversion park in the one-deep buffer; the newest wins.
      if (dval && ((state == S_LOAD) || (state == S_CONV))) begin
        pend_data  <= din;
        pend_mode  <= mode;
        pend_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (dval) begin
            data_q <= din;
            mode_q <= mode;
          end
        end
        S_LOAD: begin
          if (is_signed && data_q[WIDTH-1]) begin
            mag <= ~data_q + WIDTH'(1);
            neg <= 1'b1;
          end else begin
            mag <= data_q;
            neg <= 1'b0;
          end
          bcd     <= '0;
          bcd_ovf <= 1'b0;
          cnt     <= '0;
        end
        S_CONV: begin
          bcd     <= {bcd_adj[BCDW-2:0], mag[WIDTH-1]};
          mag     <= {mag[WIDTH-2:0], 1'b0};
          bcd_ovf <= bcd_ovf | bcd_adj[BCDW-1];
          cnt     <= cnt + CW'(1);
        end
        S_OUTPUT: begin
          disp_q <= disp_next;
          ovf_q  <= ovf_next;
          // A fresh strobe on this edge supersedes anything parked in the buffer.
          if (dval) begin
            data_q     <= din;
            mode_q     <= mode;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            data_q     <= pend_data;
            mode_q     <= pend_mode;
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign disp = en_q ? disp_q : ALL_BLANK;
  assign busy = (state != S_IDLE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_disp_num_ctrl.sv
// Randomized bench for disp_num_ctrl: an 8-bit and a 16-bit instance, checked against
// an arithmetic model of the digit rendering, plus directed strobe/reset/enable scenarios.
module tb_disp_num_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [7:0]  din8;
  logic        dval8;
  logic [1:0]  mode8;
  logic        en8;
  logic [27:0] disp8;
  logic        busy8;
  logic        ovf8;
  logic [15:0] din16;
  logic        dval16;
  logic [1:0]  mode16;
  logic        en16;
  logic [27:0] disp16;
  logic        busy16;
  logic        ovf16;

  int checks   = 0;
  int failures = 0;

  localparam logic [27:0] BLANK4 = {4{7'h7F}};

  disp_num_ctrl #(.WIDTH(8), .NDIG(4), .LZB(1)) u_dut8 (
    .clk(clk), .resetn(resetn), .din(din8), .dval(dval8), .mode(mode8),
    .enable(en8), .disp(disp8), .busy(busy8), .ovf(ovf8)
  );

  disp_num_ctrl #(.WIDTH(16), .NDIG(4), .LZB(1)) u_dut16 (
    .clk(clk), .resetn(resetn), .din(din16), .dval(dval16), .mode(mode16),
    .enable(en16), .disp(disp16), .busy(busy16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  return 7'h40;
      1:  return 7'h79;
      2:  return 7'h24;
      3:  return 7'h30;
      4:  return 7'h19;
      5:  return 7'h12;
      6:  return 7'h02;
      7:  return 7'h78;
      8:  return 7'h00;
      9:  return 7'h10;
      10: return 7'h08;
      11: return 7'h03;
      12: return 7'h46;
      13: return 7'h21;
      14: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Reference rendering built from integer arithmetic on the value itself.
  function automatic void model(input logic [31:0] v, input int w, input logic [1:0] m,
                                output logic [27:0] d, output logic o);
    longint val, mag, p;
    bit     neg;
    int     n, nn;
    val = longint'(v) & ((64'sd1 <<< w) - 64'sd1);
    d   = BLANK4;
    o   = 1'b0;
    if (m == 2'b01 || m == 2'b10) begin
      neg = (m == 2'b10) && (val >= (64'sd1 <<< (w - 1)));
      mag = neg ? (64'sd1 <<< w) - val : val;
      n = 1;
      p = 10;
      while (mag >= p) begin
        n++;
        p = p * 10;
      end
      if (mag > 9999 || (neg && n >= 4)) begin
        d[6:0] = 7'h06;
        o      = 1'b1;
      end else begin
        p = 1;
        for (int i = 0; i < n; i++) begin
          d[7*i +: 7] = seg_of(int'((mag / p) % 10));
          p = p * 10;
        end
        if (neg) d[7*n +: 7] = 7'h3F;
      end
    end else begin
      nn = (w + 3) / 4;
      for (int i = 0; i < 4; i++) begin
        if (i < nn) d[7*i +: 7] = seg_of(int'((val >> (4*i)) & 15));
      end
      o = (nn > 4);
    end
  endfunction

  function automatic logic [27:0] disp_of(input int sel);
    return (sel == 8) ? disp8 : disp16;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 8) ? busy8 : busy16;
  endfunction

  function automatic logic ovf_of(input int sel);
    return (sel == 8) ? ovf8 : ovf16;
  endfunction

  task automatic strobe(input int sel, input logic [31:0] v, input logic [1:0] m);
    @(negedge clk);
    if (sel == 8) begin
      din8 = v[7:0]; mode8 = m; dval8 = 1'b1;
    end else begin
      din16 = v[15:0]; mode16 = m; dval16 = 1'b1;
    end
    @(negedge clk);
    dval8  = 1'b0;
    dval16 = 1'b0;
  endtask

  // Latency counts clock edges from the capturing edge to the edge that updates the display.
  task automatic run_one(input int sel, input logic [31:0] v, input logic [1:0] m,
                         output logic [27:0] exp_d);
    int   lat;
    logic exp_o;
    strobe(sel, v, m);
    lat = 1;
    while (busy_of(sel) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    model(v, sel, m, exp_d, exp_o);
    check($sformatf("latency w%0d m%0d v%0h", sel, m, v), lat, (m == 2'b01 || m == 2'b10) ? sel + 3 : 3);
    check($sformatf("disp w%0d m%0d v%0h", sel, m, v), disp_of(sel), exp_d);
    check($sformatf("ovf w%0d m%0d v%0h", sel, m, v), ovf_of(sel), exp_o);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] d, d_prev, d10, d30;
    logic        o_unused;
    logic [31:0] v;
    logic [1:0]  m;
    int          sel, n;

    resetn = 1'b0;
    din8 = 8'h33; mode8 = 2'b01; dval8 = 1'b1; en8 = 1'b1;
    din16 = 16'h1234; mode16 = 2'b01; dval16 = 1'b1; en16 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset disp8", disp8, BLANK4);
    check("reset busy8", busy8, 1'b0);
    check("reset ovf8", ovf8, 1'b0);
    check("reset disp16", disp16, BLANK4);
    resetn = 1'b1;
    dval8  = 1'b0;
    dval16 = 1'b0;
    repeat (4) @(negedge clk);
    check("no start busy8", busy8, 1'b0);
    check("no start busy16", busy16, 1'b0);
    check("no start disp8", disp8, BLANK4);

    run_one(8, 32'hA5, 2'b00, d);
    check("hex A5 literal", disp8, {7'h7F, 7'h7F, 7'h08, 7'h12});
    run_one(8, 32'd200, 2'b01, d);
    check("dec 200 literal", disp8, {7'h7F, 7'h24, 7'h40, 7'h40});
    run_one(8, 32'd0, 2'b01, d);
    check("dec 0 literal", disp8, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    run_one(8, 32'h80, 2'b10, d);
    check("signed 80 literal", disp8, {7'h3F, 7'h79, 7'h24, 7'h00});
    run_one(8, 32'hFB, 2'b10, d);
    check("signed FB literal", disp8, {7'h7F, 7'h7F, 7'h3F, 7'h12});
    run_one(16, 32'hFFFF, 2'b01, d);
    check("dec FFFF literal", disp16, {7'h7F, 7'h7F, 7'h7F, 7'h06});
    check("dec FFFF ovf", ovf16, 1'b1);
    run_one(16, 32'd1234, 2'b01, d);
    check("dec 1234 literal", disp16, {7'h79, 7'h24, 7'h30, 7'h19});
    check("dec 1234 ovf", ovf16, 1'b0);
    run_one(8, 32'h3C, 2'b11, d);
    run_one(16, 32'h8000, 2'b10, d);
    run_one(16, 32'hFC19, 2'b10, d);

    repeat (40) begin
      sel = ($urandom_range(0, 1) == 1) ? 16 : 8;
      m   = 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9999)) : $urandom;
      run_one(sel, v, m, d);
    end

    run_one(8, 32'd77, 2'b01, d_prev);
    en8 = 1'b0;
    @(negedge clk);
    check("enable off blank", disp8, BLANK4);
    en8 = 1'b1;
    @(negedge clk);
    check("enable on restore", disp8, d_prev);
    mode8 = 2'b10;
    repeat (3) @(negedge clk);
    check("mode no dval disp", disp8, d_prev);
    check("mode no dval busy", busy8, 1'b0);

    model(32'd10, 8, 2'b01, d10, o_unused);
    model(32'd30, 8, 2'b01, d30, o_unused);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) check("pending early disp", disp8, d_prev);
      dval8 = (c == 0 || c == 3 || c == 5);
      din8  = (c == 0) ? 8'd10 : (c == 3) ? 8'd20 : 8'd30;
      mode8 = 2'b01;
    end
    @(negedge clk);
    check("pending first disp", disp8, d10);
    check("pending still busy", busy8, 1'b1);
    n = 0;
    while (busy8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pending second latency", n, 10);
    check("pending second disp", disp8, d30);

    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      dval8 = (c == 0 || c == 3);
      din8  = (c == 0) ? 8'd10 : 8'd20;
      mode8 = 2'b01;
    end
    @(negedge clk);
    dval8  = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("abort disp", disp8, BLANK4);
    check("abort busy", busy8, 1'b0);
    check("abort ovf", ovf8, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    check("abort later disp", disp8, BLANK4);
    check("abort later busy", busy8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
